// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scalar register file with pending-write scoreboard.
package regfile_pkg;

    localparam int unsigned REGFILE_DATA_W   = 16;
    localparam int unsigned REGFILE_NUM_REGS = 8;
    localparam int unsigned REGFILE_PIN_IDX  = REGFILE_NUM_REGS - 1;
    localparam int unsigned REGFILE_AW       = $clog2(REGFILE_NUM_REGS);

    typedef logic [REGFILE_AW-1:0]     reg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, set/clear priority and issue stall.
// Optional macro REGFILE_BYPASS_EN masks busy for registers being written back this cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = REGFILE_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned PIN_IDX  = REGFILE_PIN_IDX,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_addr_i,
    output logic [NUM_RD-1:0]    rd_busy_o,
    output logic                 stall_o,
    output logic [NUM_REGS-1:0]  busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                waw;

    // Busy bit seen by each read port.
    always_comb begin
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // A matching writeback resolves the hazard, unless a new producer issues now.
            if (wr_en_i && (wr_addr_i == rd_addr_i[k*AW +: AW]) &&
                !(iss_en_i && (iss_addr_i == rd_addr_i[k*AW +: AW]))) begin
                rd_busy_o[k] = 1'b0;
            end
`endif
        end
    end

    // WAW guard: issuing onto a register that still has an outstanding producer.
    always_comb begin
        waw = iss_en_i & busy_q[iss_addr_i];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_i && (wr_addr_i == iss_addr_i)) begin
            waw = 1'b0;
        end
`endif
    end

    assign stall_o    = (|rd_busy_o) | waw;
    assign busy_vec_o = busy_q;

    // Next busy state: clear on writeback, then set on accepted issue so set wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en_i && (wr_addr_i == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (iss_en_i && !stall_o && (iss_addr_i == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[PIN_IDX] = 1'b0;
    end

    // Busy vector register, dropped entirely on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/scalar_regfile_sb.sv
// Scalar register file with one pinned index, NUM_RD combinational read ports, one write port
// and an integrated pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to matching reads.
module scalar_regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = REGFILE_DATA_W,
    parameter int unsigned NUM_REGS = REGFILE_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned PIN_IDX  = NUM_REGS - 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [DATA_W-1:0]        pin_data_i,
    input  logic                     iss_en_i,
    input  logic [AW-1:0]            iss_addr_i,
    output logic                     stall_o,
    output logic [NUM_REGS-1:0]      busy_vec_o
);

    localparam logic [AW-1:0] PIN_ADDR = AW'(PIN_IDX);

    logic [DATA_W-1:0] reg_val [NUM_REGS];

    // Storage: the pinned index has no flops; its slot is never selected by the read mux.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == PIN_IDX) begin : g_pin
            assign reg_val[i] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] val;

            // One physical register, written on a matching writeback.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val <= '0;
                end else if (wr_en_i && (wr_addr_i == AW'(i))) begin
                    val <= wr_data_i;
                end
            end

            assign reg_val[i] = val;
        end
    end

    // Read muxes: pinned index returns the live value, others the stored (or bypassed) data.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_addr_i[k*AW +: AW] == PIN_ADDR) begin
                rd_data_o[k*DATA_W +: DATA_W] = pin_data_i;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_en_i && (wr_addr_i == rd_addr_i[k*AW +: AW])) begin
                rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
`endif
            end else begin
                rd_data_o[k*DATA_W +: DATA_W] = reg_val[rd_addr_i[k*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .PIN_IDX  (PIN_IDX)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .rd_busy_o  (rd_busy_o),
        .stall_o    (stall_o),
        .busy_vec_o (busy_vec_o)
    );

endmodule

// File: doc/scalar_regfile_sb.md
# scalar_regfile_sb

Parametrised scalar register file with an integrated pending-write scoreboard, the successor to the fixed 8×16 scalar register file in the scalar datapath. It provides `NUM_RD` combinational read ports and one synchronous write port. One register index is pinned to an external live value, for example the PC. A per-register busy bit is set at issue and cleared at writeback, so the decode stage can stall on RAW and WAW hazards without a separate scoreboard block.

## Interface
Parameters:
- `DATA_W`, 16: register width in bits
- `NUM_REGS`, 8: register count; must be a power of two, ≥ 2
- `NUM_RD`, 2: number of read ports, 1..4
- `PIN_IDX`, `NUM_REGS`-1: index whose reads return `pin_data_i`
- `AW`, $clog2(`NUM_REGS`): address width; derived, not overridable

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge
- `rst_n`, in, 1: reset, asynchronous and active-low
- `rd_addr_i`, in, `NUM_RD`×`AW`: read addresses
- `rd_data_o`, out, `NUM_RD`×`DATA_W`: read data
- `rd_busy_o`, out, `NUM_RD`: busy bit of each addressed register
- `wr_en_i`, in, 1: writeback strobe
- `wr_addr_i`, in, `AW`: writeback destination
- `wr_data_i`, in, `DATA_W`: writeback data
- `pin_data_i`, in, `DATA_W`: live value for `PIN_IDX`
- `iss_en_i`, in, 1: instruction issue; marks destination pending
- `iss_addr_i`, in, `AW`: issued destination
- `stall_o`, out, 1: issue must be held this cycle
- `busy_vec_o`, out, `NUM_REGS`: full scoreboard, for debug and hazard units

## Operation
- **Storage:** `NUM_REGS`−1 physical registers. `PIN_IDX` has no storage. Reads of `PIN_IDX` return `pin_data_i`. Writes to `PIN_IDX` are discarded.
- **Read:** purely combinational, `rd_data_o[k] = reg[rd_addr_i[k]]`, or `pin_data_i` when the address is `PIN_IDX`.
- **Write:** on the rising edge with `wr_en_i`=1, `reg[wr_addr_i]` <= `wr_data_i`. Full width, no truncation or extension.
- **Scoreboard:** each bit `busy[i]` evolves on the rising edge as follows.
  - Set when `iss_en_i` and `iss_addr_i`==i and `stall_o`==0.
  - Cleared when `wr_en_i` and `wr_addr_i`==i.
  - If set and clear hit the same index in the same cycle, set wins, because a new producer supersedes the old one.
  - `busy[PIN_IDX]` is constant 0.
- **`rd_busy_o[k]`** = `busy[rd_addr_i[k]]`.
- **`stall_o`** = (OR of `rd_busy_o`) OR (`iss_en_i` AND `busy[iss_addr_i]`). The second term is a WAW guard. A writeback clearing that bit in the same cycle does not suppress the stall unless bypass is enabled (see Configuration).
- **Stalled issue:** leaves the scoreboard unchanged.
- **Reset (`rst_n`=0):** all stored registers and all busy bits are cleared immediately, without waiting for a clock edge, and writes or issues that cycle are ignored.
  - Outputs during reset: `rd_data_o` = 0 (or `pin_data_i` for `PIN_IDX`), `rd_busy_o` = 0, `busy_vec_o` = 0, `stall_o` = 0.
  - Reset asserted mid-operation drops all pending entries. In-flight writebacks after reset write data but find busy already 0.

## Timing
- Write-to-read latency is 1 cycle; the new value is visible the cycle after the write edge.
- Issue-to-busy latency is 1 cycle.
- Writeback-to-not-busy latency is 1 cycle.
- `stall_o` is combinational from inputs and current state; there is no registered output.
- Two writes to the same address in consecutive cycles: the last one wins; there is no merging.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** a read whose address equals `wr_addr_i` while `wr_en_i`=1 (and is not `PIN_IDX`) behaves as follows.
  - It returns `wr_data_i` in the same cycle.
  - Its `rd_busy_o` is forced to 0, unless the same index is also being issued that cycle.
  - The WAW term of `stall_o` is likewise masked by a matching writeback.
  - Write-to-read latency becomes 0.
- **Not defined:** no forwarding; behaviour is exactly as in Operation.

## Structure
- Package `regfile_pkg`:
  - Default parameter constants `REGFILE_DATA_W`, `REGFILE_NUM_REGS`, `REGFILE_PIN_IDX`.
  - Typedefs `reg_addr_t` and `reg_data_t`.
- Sub-module `regfile_scoreboard` holds the busy vector, the set/clear priority and the stall logic.
- The top module holds storage, the read muxes and bypass.

## Test plan
All scenarios use the defaults (16-bit, 8 registers, `PIN_IDX`=7, 2 read ports).
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-cycle, `pin_data_i`=0x1234.
  - Expected: all reads of r0..r6 return 0, a read of r7 returns 0x1234, `busy_vec_o`=0, `stall_o`=0, all without a clock edge.
- **Write/read:**
  - Stimulus: write 0xBEEF to r3.
  - Expected: the next cycle `rd_addr_i[0]`=3 returns 0xBEEF.
  - Stimulus: write 0xAAAA to r7.
  - Expected: a read of r7 still returns `pin_data_i`.
- **Scoreboard:**
  - Stimulus: issue r2, then read r2 the next cycle.
  - Expected: `rd_busy_o[0]`=1 and `stall_o`=1.
  - Stimulus: writeback r2.
  - Expected: the following cycle busy=0 and `stall_o`=0.
- **Set-vs-clear:**
  - Stimulus: issue r4 and writeback r4 in the same cycle.
  - Expected: `busy_vec_o[4]`=1 afterwards.
  - Stimulus: a stalled issue to r5.
  - Expected: `busy_vec_o[5]` is unchanged.
- **Bypass (run once with and once without `REGFILE_BYPASS_EN`):**
  - Stimulus: write 0x5A5A to r1 while reading r1, with r1 busy.
  - Expected with the macro: same-cycle `rd_data_o`=0x5A5A and `rd_busy_o`=0.
  - Expected without the macro: old data and `rd_busy_o`=1.
- **Reset mid-pending:**
  - Stimulus: issue r1, r2, r3, then pulse `rst_n` low.
  - Expected: `busy_vec_o`=0 immediately, and a later writeback to r2 stores its data without error.
